// File: rtl/maxpool_pkg.sv
// rtl/maxpool_pkg.sv - shared element width, controller states and counter-width helper for maxpool_layer
package maxpool_pkg;

  localparam int FP32_W = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    EDGE  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Bits needed to count 0..n-1
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fp_max2.sv
// rtl/fp_max2.sv - combinational max of two fp32 operands by sign-magnitude compare; NaN is not handled
module fp_max2
  import maxpool_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic [FP32_W-1:0] y
);

  logic a_mag_gt;

  assign a_mag_gt = a[FP32_W-2:0] > b[FP32_W-2:0];

  always_comb begin
    y = a;
    if (a[FP32_W-1] != b[FP32_W-1]) y = a[FP32_W-1] ? b : a;
    else if (a[FP32_W-1])           y = a_mag_gt ? b : a;
    else                            y = a_mag_gt ? a : b;
  end

endmodule

// File: rtl/maxpool_layer.sv
// rtl/maxpool_layer.sv - multi-channel 2x2 fp32 max-pool; stride 2 always, stride 1 when MAXPOOL_STRIDE1_EN is defined
module maxpool_layer
  import maxpool_pkg::*;
#(
  parameter int CHANNELS   = 32,
  parameter int ELEM_WIDTH = 32,
  parameter int IMG_SIZE   = 208,
  parameter int STRIDE     = 2
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [CHANNELS*ELEM_WIDTH-1:0] data_in,
  input  logic                           valid_in,
  output logic                           ready_in,
  output logic [CHANNELS*ELEM_WIDTH-1:0] data_out,
  output logic                           valid_out,
  output logic                           last_out
);

  localparam int BUS_W = CHANNELS * ELEM_WIDTH;
  localparam int RC_W  = cnt_w(IMG_SIZE);
  localparam logic [RC_W-1:0] LAST = RC_W'(IMG_SIZE - 1);

  if (ELEM_WIDTH != FP32_W || IMG_SIZE < 2 || (STRIDE == 2 && IMG_SIZE % 2 != 0)) begin : g_bad_cfg
    $error("maxpool_layer: unsupported ELEM_WIDTH/IMG_SIZE combination");
  end

  state_t          state;
  logic [RC_W-1:0] row, col, lb_addr;
  logic            accept, col_end, row_end, emit, emit_last;

  logic [BUS_W-1:0] line_buf [IMG_SIZE];
  logic [BUS_W-1:0] lb_rd, prev_cur, prev_up, b_op, cm_a, cm_b, fin, pool_nxt;

  assign accept  = valid_in & ready_in;
  assign col_end = (col == LAST);
  assign row_end = (row == LAST);

`ifdef MAXPOOL_STRIDE1_EN
  localparam bit S1 = (STRIDE == 1);

  if (STRIDE != 1 && STRIDE != 2) begin : g_bad_stride
    $error("maxpool_layer: STRIDE must be 1 or 2");
  end

  // ready_in follows the next state only, never valid_in
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= RUN;
      ready_in <= 1'b1;
    end else if (S1) begin
      case (state)
        RUN: if (accept && col_end && row != '0) begin
          state    <= EDGE;
          ready_in <= 1'b0;
        end
        EDGE: if (row == '0) begin
          state <= DRAIN;
        end else begin
          state    <= RUN;
          ready_in <= 1'b1;
        end
        DRAIN: if (col_end) begin
          state    <= RUN;
          ready_in <= 1'b1;
        end
        default: begin
          state    <= RUN;
          ready_in <= 1'b1;
        end
      endcase
    end
  end
`else
  localparam bit S1 = 1'b0;

  if (STRIDE != 2) begin : g_bad_stride
    $error("maxpool_layer: STRIDE must be 2 without MAXPOOL_STRIDE1_EN");
  end

  assign state    = RUN;
  assign ready_in = 1'b1;
`endif

  // DRAIN reads one column ahead while prev_cur carries the column being emitted
  assign lb_addr = (state == DRAIN && !col_end) ? col + RC_W'(1) : col;
  assign lb_rd   = line_buf[lb_addr];
  assign b_op    = (state == DRAIN) ? prev_cur : data_in;

  always_ff @(posedge Clk) begin
    if (accept) begin
      line_buf[col] <= data_in;
      prev_cur      <= data_in;
      prev_up       <= lb_rd;
    end else if (state != RUN) begin
      prev_cur <= lb_rd;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam int LO = k * FP32_W;
    fp_max2 u_col_a (.a(prev_up[LO +: FP32_W]), .b(prev_cur[LO +: FP32_W]), .y(cm_a[LO +: FP32_W]));
    fp_max2 u_col_b (.a(lb_rd[LO +: FP32_W]),   .b(b_op[LO +: FP32_W]),     .y(cm_b[LO +: FP32_W]));
    fp_max2 u_fin   (.a(cm_a[LO +: FP32_W]),    .b(cm_b[LO +: FP32_W]),     .y(fin[LO +: FP32_W]));
  end

  always_comb begin
    pool_nxt  = fin;
    emit      = 1'b0;
    emit_last = 1'b0;
    case (state)
      EDGE: begin
        pool_nxt = cm_a;
        emit     = 1'b1;
      end
      DRAIN: begin
        pool_nxt  = col_end ? prev_cur : cm_b;
        emit      = 1'b1;
        emit_last = col_end;
      end
      default: begin
        if (S1) begin
          emit = accept && row != '0 && col != '0;
        end else begin
          emit      = accept && row[0] && col[0];
          emit_last = emit && row_end && col_end;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      row       <= '0;
      col       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      if (accept || state == DRAIN) col <= col_end ? '0 : col + RC_W'(1);
      if (accept && col_end)        row <= row_end ? '0 : row + RC_W'(1);
      valid_out <= emit;
      last_out  <= emit_last;
      if (emit) data_out <= pool_nxt;
    end
  end

endmodule

// File: tb/tb_maxpool_layer.sv
// tb/tb_maxpool_layer.sv - scoreboard bench for maxpool_layer; stride-1 cases build when MAXPOOL_STRIDE1_EN is defined
module tb_maxpool_layer;

  localparam int N2 = 4;
  localparam int C2 = 4;
  localparam int N1 = 3;
  localparam int C1 = 2;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];

  logic [C2*32-1:0] di2, do2;
  logic             vi2, rdy2, vo2, lo2;
  int               n_out2 = 0, n_last2 = 0;
  int               fi[N2*N2];

  maxpool_layer #(.CHANNELS(C2), .ELEM_WIDTH(32), .IMG_SIZE(N2), .STRIDE(2)) u_s2 (
    .Clk(Clk), .Rst(Rst), .data_in(di2), .valid_in(vi2), .ready_in(rdy2),
    .data_out(do2), .valid_out(vo2), .last_out(lo2)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] i2f(input int n);
    logic s;
    int   m, e;
    if (n == 0) return 32'h0;
    s = (n < 0);
    m = s ? -n : n;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    return {s, 8'(127 + e), 23'((m << (23 - e)) & 32'h007f_ffff)};
  endfunction

  function automatic logic [127:0] scaled(input int n, input int ch);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < ch; k++) v[k*32 +: 32] = i2f(n * (k + 1));
    return v;
  endfunction

  always @(negedge Clk) begin
    if (Rst && vo2) begin
      n_out2++;
      if (lo2) n_last2++;
      if (q2.size() == 0) chk("s2_unexpected_valid", vo2, 1'b0);
      else begin
        exp_t e;
        e = q2.pop_front();
        chk("s2_data", do2, e.data);
        chk("s2_last", lo2, e.last);
      end
    end else if (Rst && lo2) begin
      chk("s2_stray_last", lo2, 1'b0);
    end
  end

  task automatic drive2(input logic [127:0] px, input int gap);
    for (int g = 0; g < gap; g++) begin
      vi2 = 1'b0;
      di2 = {$urandom, $urandom, $urandom, $urandom};
      @(posedge Clk); #1;
    end
    di2 = px;
    vi2 = 1'b1;
    chk("s2_ready", rdy2, 1'b1);
    @(posedge Clk); #1;
    vi2 = 1'b0;
  endtask

  task automatic frame2(input int maxgap, input int npix);
    int   m, r, c;
    exp_t e;
    for (int p = 0; p < npix; p++) begin
      r = p / N2;
      c = p % N2;
      if (r % 2 == 1 && c % 2 == 1) begin
        m = fi[p];
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (fi[(r - dr) * N2 + c - dc] > m) m = fi[(r - dr) * N2 + c - dc];
        e.data = scaled(m, C2);
        e.last = (p == N2 * N2 - 1);
        q2.push_back(e);
      end
      drive2(scaled(fi[p], C2), int'($urandom_range(0, maxgap)));
    end
  endtask

`ifdef MAXPOOL_STRIDE1_EN
  logic [C1*32-1:0] di1, do1;
  logic             vi1, rdy1, vo1, lo1;
  int               n_out1 = 0, n_last1 = 0;
  int               fi1[N1*N1];

  maxpool_layer #(.CHANNELS(C1), .ELEM_WIDTH(32), .IMG_SIZE(N1), .STRIDE(1)) u_s1 (
    .Clk(Clk), .Rst(Rst), .data_in(di1), .valid_in(vi1), .ready_in(rdy1),
    .data_out(do1), .valid_out(vo1), .last_out(lo1)
  );

  always @(negedge Clk) begin
    if (Rst && vo1) begin
      n_out1++;
      if (lo1) n_last1++;
      if (q1.size() == 0) chk("s1_unexpected_valid", vo1, 1'b0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("s1_data", do1, e.data);
        chk("s1_last", lo1, e.last);
      end
    end else if (Rst && lo1) begin
      chk("s1_stray_last", lo1, 1'b0);
    end
  end

  function automatic int win1(input int i, input int j);
    int m;
    m = fi1[i * N1 + j];
    for (int a = i; a <= i + 1 && a < N1; a++)
      for (int b = j; b <= j + 1 && b < N1; b++)
        if (fi1[a * N1 + b] > m) m = fi1[a * N1 + b];
    return m;
  endfunction

  task automatic push1(input int i, input int j, input logic last);
    exp_t e;
    e.data = scaled(win1(i, j), C1);
    e.last = last;
    q1.push_back(e);
  endtask

  task automatic drive1(input logic [63:0] px, input int gap, output int waited);
    waited = 0;
    for (int g = 0; g < gap; g++) begin
      vi1 = 1'b0;
      di1 = {$urandom, $urandom};
      @(posedge Clk); #1;
    end
    di1 = px;
    vi1 = 1'b1;
    while (!rdy1 && waited < 32) begin
      @(posedge Clk); #1;
      waited++;
    end
    chk("s1_ready", rdy1, 1'b1);
    @(posedge Clk); #1;
    vi1 = 1'b0;
  endtask

  task automatic frame1(input int maxgap, input bit check_waits);
    int r, c, w;
    for (int p = 0; p < N1 * N1; p++) begin
      r = p / N1;
      c = p % N1;
      if (r >= 1 && c >= 1) push1(r - 1, c - 1, 1'b0);
      if (r >= 1 && c == N1 - 1) push1(r - 1, N1 - 1, 1'b0);
      if (r == N1 - 1 && c == N1 - 1)
        for (int j = 0; j < N1; j++) push1(N1 - 1, j, j == N1 - 1);
      drive1(scaled(fi1[p], C1), int'($urandom_range(0, maxgap)), w);
      if (check_waits) chk("s1_wait", w, (c == 0 && r >= 2) ? 1 : 0);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base, bl, lo;
    logic [31:0] sg[N2*N2];
    logic [31:0] ex[4];
    int          k;
    exp_t        e;

    vi2 = 1'b0;
    di2 = '0;
`ifdef MAXPOOL_STRIDE1_EN
    vi1 = 1'b0;
    di1 = '0;
`endif
    @(posedge Clk); #1;
    chk("s2_rst_ready", rdy2, 1'b1);
    chk("s2_rst_valid", vo2, 1'b0);
    chk("s2_rst_last", lo2, 1'b0);
    chk("s2_rst_data", do2, '0);
`ifdef MAXPOOL_STRIDE1_EN
    chk("s1_rst_ready", rdy1, 1'b1);
    chk("s1_rst_valid", vo1, 1'b0);
    chk("s1_rst_data", do1, '0);
`endif
    @(posedge Clk); #1;
    Rst = 1'b1;

    // stride 2, raster 1..16 without gaps
    for (int i = 0; i < N2 * N2; i++) fi[i] = i + 1;
    frame2(0, N2 * N2);
    repeat (2) @(posedge Clk); #1;
    chk("s2_ramp_outputs", n_out2, 4);
    chk("s2_ramp_lasts", n_last2, 1);
    chk("s2_ramp_q_empty", q2.size(), 0);

    // stride 2, signed zeros and negatives
    sg = '{i2f(-3), i2f(-1), 32'h0000_0000, 32'h8000_0000,
           32'h8000_0000, i2f(-2), i2f(-5), i2f(-1),
           i2f(1), i2f(2), i2f(3), i2f(4),
           i2f(5), i2f(6), i2f(7), i2f(8)};
    ex = '{32'h8000_0000, 32'h0000_0000, i2f(6), i2f(8)};
    k = 0;
    for (int p = 0; p < N2 * N2; p++) begin
      if ((p / N2) % 2 == 1 && (p % N2) % 2 == 1) begin
        e.data = {4{ex[k]}};
        e.last = (p == N2 * N2 - 1);
        q2.push_back(e);
        k++;
      end
      drive2({4{sg[p]}}, 0);
    end

    // stride 2, random signed values with random valid gaps
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N2 * N2; i++) fi[i] = int'($urandom_range(0, 200)) - 100;
      frame2(3, N2 * N2);
    end
    repeat (2) @(posedge Clk); #1;
    chk("s2_rand_q_empty", q2.size(), 0);

    // stride 2, reset after pixel 10, then a clean frame
    for (int i = 0; i < N2 * N2; i++) fi[i] = 50 - i;
    frame2(0, 10);
    @(negedge Clk); #1;
    Rst = 1'b0;
    #1;
    chk("s2_midrst_valid", vo2, 1'b0);
    chk("s2_midrst_data", do2, '0);
    chk("s2_midrst_q_empty", q2.size(), 0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    base = n_out2;
    for (int i = 0; i < N2 * N2; i++) fi[i] = int'($urandom_range(0, 90)) - 30;
    frame2(1, N2 * N2);
    repeat (2) @(posedge Clk); #1;
    chk("s2_post_rst_outputs", n_out2 - base, 4);
    chk("s2_post_rst_q_empty", q2.size(), 0);

`ifdef MAXPOOL_STRIDE1_EN
    // stride 1, raster 1..9 without gaps
    for (int i = 0; i < N1 * N1; i++) fi1[i] = i + 1;
    frame1(0, 1'b1);
    lo = 0;
    while (!rdy1 && lo < 32) begin
      @(posedge Clk); #1;
      lo++;
    end
    chk("s1_ready_low_after_last", lo, 1 + N1);
    repeat (3) @(posedge Clk); #1;
    chk("s1_ramp_outputs", n_out1, N1 * N1);
    chk("s1_ramp_lasts", n_last1, 1);
    chk("s1_ramp_q_empty", q1.size(), 0);

    // stride 1, reset during DRAIN drops the rest of the frame
    for (int i = 0; i < N1 * N1; i++) fi1[i] = int'($urandom_range(0, 60)) - 30;
    frame1(0, 1'b0);
    repeat (2) @(posedge Clk);
    @(negedge Clk); #1;
    Rst = 1'b0;
    q1.delete();
    #1;
    chk("s1_drainrst_valid", vo1, 1'b0);
    chk("s1_drainrst_ready", rdy1, 1'b1);
    @(posedge Clk); #1;
    Rst = 1'b1;
    repeat (3) @(posedge Clk); #1;
    chk("s1_after_rst_ready", rdy1, 1'b1);

    // stride 1, two back-to-back frames with random gaps
    base = n_out1;
    bl   = n_last1;
    for (int i = 0; i < N1 * N1; i++) fi1[i] = int'($urandom_range(0, 60)) - 30;
    frame1(2, 1'b0);
    for (int i = 0; i < N1 * N1; i++) fi1[i] = int'($urandom_range(0, 60)) - 30;
    frame1(0, 1'b0);
    repeat (8) @(posedge Clk); #1;
    chk("s1_b2b_outputs", n_out1 - base, 2 * N1 * N1);
    chk("s1_b2b_lasts", n_last1 - bl, 2);
    chk("s1_b2b_q_empty", q1.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
